// File: rtl/hlink_fifo_buf.sv
// hlink_fifo_buf: HLINK activation buffer between neighbouring cores.
// Runs as the legacy overwrite register or as a show-ahead valid/ready FIFO.
`ifndef MAC_MULT_NUM
`define MAC_MULT_NUM 4
`endif
`ifndef IDATA_WIDTH
`define IDATA_WIDTH 8
`endif
module hlink_fifo_buf #(
  parameter int DATA_WIDTH = `MAC_MULT_NUM*`IDATA_WIDTH,
  parameter int DEPTH      = 4,
  parameter int CNT_WIDTH  = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_fifo_mode,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] hlink_wdata,
  input  logic                  hlink_wen,
  output logic                  hlink_wready,
  output logic [DATA_WIDTH-1:0] hlink_rdata,
  output logic                  hlink_rvalid,
  input  logic                  hlink_rready,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  ovf_err
);
  localparam int AW = $clog2(DEPTH);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic ovf_q, ovf_d, mode_q, mode_d;
  logic clr, push, pop;
  // REG mode keeps both pointers at 0, so entry 0 is the register and count is the valid pulse
  assign fifo_count   = count_q;
  assign fifo_full    = count_q == CNT_WIDTH'(DEPTH);
  assign fifo_empty   = count_q == '0;
  assign hlink_rvalid = !fifo_empty;
  assign hlink_wready = !fifo_full;
  assign hlink_rdata  = mem_q[rd_ptr_q];
  assign ovf_err      = ovf_q;
  always_comb begin
    clr = flush || (cfg_fifo_mode != mode_q);
    push = !clr && hlink_wen && hlink_wready;
    pop = !clr && cfg_fifo_mode && hlink_rvalid && hlink_rready;
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = hlink_wdata;
    wr_ptr_d = clr ? '0 : wr_ptr_q + AW'(push && cfg_fifo_mode);
    rd_ptr_d = clr ? '0 : rd_ptr_q + AW'(pop);
    count_d = clr ? '0 : cfg_fifo_mode ? count_q + CNT_WIDTH'(push) - CNT_WIDTH'(pop) : CNT_WIDTH'(push);
    ovf_d = !clr && (ovf_q || (hlink_wen && fifo_full));
    mode_d = cfg_fifo_mode;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      mode_q   <= mode_d;
    end
  end
endmodule

// File: tb/tb_hlink_fifo_buf.sv
// tb_hlink_fifo_buf: directed and random stimulus against a queue-based reference model.
module tb_hlink_fifo_buf;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH+1);
  logic clk = 1'b0, rstn = 1'b1;
  logic cfg_fifo_mode = 1'b0, flush = 1'b0, hlink_wen = 1'b0, hlink_rready = 1'b0;
  logic [DW-1:0] hlink_wdata = '0;
  logic hlink_wready, hlink_rvalid, fifo_full, fifo_empty, ovf_err;
  logic [DW-1:0] hlink_rdata;
  logic [CW-1:0] fifo_count;
  int n_cmp = 0, n_bad = 0;
  logic [DW-1:0] exp_q [$];
  bit m_ovf = 0, m_mode = 0, m_rv = 0, m_known = 1;
  logic [DW-1:0] m_rd = '0;

  hlink_fifo_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .cfg_fifo_mode(cfg_fifo_mode), .flush(flush),
    .hlink_wdata(hlink_wdata), .hlink_wen(hlink_wen), .hlink_wready(hlink_wready),
    .hlink_rdata(hlink_rdata), .hlink_rvalid(hlink_rvalid), .hlink_rready(hlink_rready),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .fifo_empty(fifo_empty), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO is a plain queue; REG mode is last word plus a one-cycle pulse
  always @(posedge clk) begin
    if (!rstn) begin
      exp_q.delete(); m_ovf = 0; m_mode = 0; m_rv = 0; m_rd = '0; m_known = 1;
    end else begin
      if (flush || cfg_fifo_mode != m_mode) begin
        exp_q.delete(); m_ovf = 0; m_rv = 0;
        if (cfg_fifo_mode != m_mode && !cfg_fifo_mode) m_known = 0;
      end else if (cfg_fifo_mode) begin
        bit full;
        full = exp_q.size() == DEPTH;
        if (hlink_wen && full) m_ovf = 1;
        if (hlink_rready && exp_q.size() > 0) void'(exp_q.pop_front());
        if (hlink_wen && !full) exp_q.push_back(hlink_wdata);
      end else begin
        m_rv = hlink_wen;
        if (hlink_wen) begin m_rd = hlink_wdata; m_known = 1; end
      end
      m_mode = cfg_fifo_mode;
    end
  end

  // Monitor: compares DUT outputs with the model every cycle, head data whenever rvalid is shown
  always @(posedge clk) begin
    #1;
    if (rstn) begin
      if (m_mode) begin
        chk("fifo_count", fifo_count, exp_q.size());
        chk("rvalid", hlink_rvalid, exp_q.size() > 0);
        chk("full", fifo_full, exp_q.size() == DEPTH);
        chk("empty", fifo_empty, exp_q.size() == 0);
        chk("wready", hlink_wready, exp_q.size() != DEPTH);
        chk("ovf_err", ovf_err, m_ovf);
        if (exp_q.size() > 0) chk("head_data", hlink_rdata, exp_q[0]);
      end else begin
        chk("reg_rvalid", hlink_rvalid, m_rv);
        chk("reg_count", fifo_count, m_rv);
        chk("reg_full", fifo_full, 0);
        chk("reg_empty", fifo_empty, !m_rv);
        chk("reg_wready", hlink_wready, 1);
        chk("reg_ovf", ovf_err, 0);
        if (m_known) chk("reg_rdata", hlink_rdata, m_rd);
      end
    end
  end

  task automatic drive(input bit m, input bit f, input bit w, input logic [DW-1:0] d, input bit r);
    @(negedge clk);
    cfg_fifo_mode = m; flush = f; hlink_wen = w; hlink_wdata = d; hlink_rready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_count"}, fifo_count, 0);
    chk({tag, "_empty"}, fifo_empty, 1);
    chk({tag, "_full"}, fifo_full, 0);
    chk({tag, "_wready"}, hlink_wready, 1);
    chk({tag, "_rvalid"}, hlink_rvalid, 0);
    chk({tag, "_rdata"}, hlink_rdata, 0);
    chk({tag, "_ovf"}, ovf_err, 0);
  endtask

  logic [DW-1:0] fill [4] = '{32'h11, 32'h22, 32'h33, 32'h44};

  initial begin
    #1 rstn = 1'b0;
    #1 chk_reset_vals("por");
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    // REG mode
    drive(0, 0, 1, 32'hA5, 0);
    chk("s1_rvalid", hlink_rvalid, 1); chk("s1_rdata", hlink_rdata, 32'hA5);
    drive(0, 0, 0, 32'h0, 1);
    chk("s1_pulse", hlink_rvalid, 0); chk("s1_hold", hlink_rdata, 32'hA5);
    drive(0, 0, 1, 32'h3C, 0);
    chk("s1_rdata2", hlink_rdata, 32'h3C);
    drive(0, 0, 0, 32'h0, 0);
    chk("s1_hold2", hlink_rdata, 32'h3C);
    // FIFO fill, overflow, drain
    drive(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 1, fill[i], 0);
      chk("s2_count", fifo_count, i + 1);
    end
    chk("s2_full", fifo_full, 1); chk("s2_wready", hlink_wready, 0);
    drive(1, 0, 1, 32'h55, 0);
    chk("s2_ovf", ovf_err, 1); chk("s2_count_ovf", fifo_count, 4);
    for (int i = 0; i < 4; i++) begin
      chk("s2_head", hlink_rdata, fill[i]);
      drive(1, 0, 0, 32'h0, 1);
    end
    chk("s2_empty", fifo_empty, 1); chk("s2_rvalid", hlink_rvalid, 0);
    // flush with count 3 and ovf set, while pushing
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 32'h60 + i, 0);
    chk("s4_pre_count", fifo_count, 3); chk("s4_pre_ovf", ovf_err, 1);
    drive(1, 1, 1, 32'hEE, 0);
    chk("s4_count", fifo_count, 0); chk("s4_empty", fifo_empty, 1); chk("s4_ovf", ovf_err, 0);
    drive(1, 0, 1, 32'h77, 0);
    chk("s4_next", hlink_rdata, 32'h77);
    // wrap with simultaneous push and pop
    drive(1, 0, 1, 32'h78, 0);
    for (int i = 0; i < 10; i++) begin
      drive(1, 0, 1, 32'h80 + i, 1);
      chk("s3_count", fifo_count, 2);
    end
    chk("s3_head", hlink_rdata, 32'h88);
    // mode toggle to REG flushes
    drive(0, 0, 1, 32'hDD, 0);
    chk("s5_count", fifo_count, 0); chk("s5_rvalid", hlink_rvalid, 0);
    drive(0, 0, 1, 32'hA5, 0);
    chk("s5_rvalid2", hlink_rvalid, 1); chk("s5_rdata", hlink_rdata, 32'hA5);
    // async reset mid-cycle with count 3
    drive(1, 0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 1, 32'h90 + i, 0);
    chk("s6_pre", fifo_count, 3);
    @(negedge clk);
    hlink_wen = 1'b0;
    #2 rstn = 1'b0;
    #1 chk_reset_vals("async");
    @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    drive(1, 0, 0, 32'h0, 0);
    drive(1, 0, 1, 32'h5A, 0);
    chk("s6_rvalid", hlink_rvalid, 1); chk("s6_rdata", hlink_rdata, 32'h5A);
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      bit m;
      m = ($urandom_range(63) == 0) ? !cfg_fifo_mode : cfg_fifo_mode;
      drive(m, $urandom_range(31) == 0, $urandom_range(2) != 0, $urandom, $urandom_range(1) == 1);
    end
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
